// File: rtl/reg_checkpoint_monitor.sv
// reg_checkpoint_monitor
//   Waits a programmed number of cycles after arm, then walks a table of
//   (register index, expected value) entries through a register-file debug
//   read port and reports pass/fail, mismatch count and the first failure.
//
//   state | meaning
//   IDLE  | out of reset, table may be written, waiting for arm
//   COUNT | counting cycles up to the latched target
//   SCAN  | one table entry compared per cycle
//   DONE  | results valid and held until next arm or rst
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cfg_we/idx/en/reg/val    table entry write (IDLE/DONE only)
//   target_cycle, arm        checkpoint cycle (sampled at arm) and start pulse
//   rd_addr, rd_data         register-file debug read port
//   busy, done, pass         status
//   mismatch_cnt, fail_idx,
//   fail_data, cycle_cnt     results and checkpoint counter
module reg_checkpoint_monitor #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_CHECKS = 8,
  parameter int IDX_W      = 3,
  parameter int CYCLE_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [ADDR_W-1:0]  cfg_reg,
  input  logic [DATA_W-1:0]  cfg_val,
  input  logic [CYCLE_W-1:0] target_cycle,
  input  logic               arm,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [IDX_W:0]     mismatch_cnt,
  output logic [IDX_W-1:0]   fail_idx,
  output logic [DATA_W-1:0]  fail_data,
  output logic [CYCLE_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHECKS - 1);
  localparam logic [IDX_W:0]   NUM_LIMIT = (IDX_W+1)'(NUM_CHECKS);

  state_t              state_q, state_d;
  logic [NUM_CHECKS-1:0] en_q, en_d;
  logic [ADDR_W-1:0]   reg_q [NUM_CHECKS];
  logic [ADDR_W-1:0]   reg_d [NUM_CHECKS];
  logic [DATA_W-1:0]   val_q [NUM_CHECKS];
  logic [DATA_W-1:0]   val_d [NUM_CHECKS];
  logic [CYCLE_W-1:0]  target_q, target_d;
  logic [CYCLE_W-1:0]  cycle_q, cycle_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      mcnt_q, mcnt_d;
  logic [IDX_W-1:0]    fidx_q, fidx_d;
  logic [DATA_W-1:0]   fdata_q, fdata_d;
  logic                cfg_ok;

  assign cfg_ok = (state_q == IDLE) || (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    reg_d    = reg_q;
    val_d    = val_q;
    target_d = target_q;
    cycle_d  = cycle_q;
    idx_d    = idx_q;
    mcnt_d   = mcnt_q;
    fidx_d   = fidx_q;
    fdata_d  = fdata_q;

    // The table is only read during SCAN, so a write issued with arm is
    // naturally visible to the run it starts.
    if (cfg_ok && cfg_we && ({1'b0, cfg_idx} < NUM_LIMIT)) begin
      en_d[cfg_idx]  = cfg_en;
      reg_d[cfg_idx] = cfg_reg;
      val_d[cfg_idx] = cfg_val;
    end

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          target_d = (target_cycle == '0) ? CYCLE_W'(1) : target_cycle;
          cycle_d  = CYCLE_W'(1);
          mcnt_d   = '0;
          fidx_d   = '0;
          fdata_d  = '0;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (cycle_q == target_q) begin
          state_d = SCAN;
          idx_d   = '0;
        end else if (cycle_q != '1) begin
          cycle_d = cycle_q + CYCLE_W'(1);
        end
      end
      SCAN: begin
        if (en_q[idx_q] && (rd_data != val_q[idx_q])) begin
          mcnt_d = mcnt_q + 1'b1;
          if (mcnt_q == '0) begin
            fidx_d  = idx_q;
            fdata_d = rd_data;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      en_q     <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        reg_q[i] <= '0;
        val_q[i] <= '0;
      end
      target_q <= '0;
      cycle_q  <= '0;
      idx_q    <= '0;
      mcnt_q   <= '0;
      fidx_q   <= '0;
      fdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      reg_q    <= reg_d;
      val_q    <= val_d;
      target_q <= target_d;
      cycle_q  <= cycle_d;
      idx_q    <= idx_d;
      mcnt_q   <= mcnt_d;
      fidx_q   <= fidx_d;
      fdata_q  <= fdata_d;
    end
  end

  assign rd_addr      = (state_q == SCAN) ? reg_q[idx_q] : '0;
  assign busy         = (state_q == COUNT) || (state_q == SCAN);
  assign done         = (state_q == DONE);
  assign pass         = done && (mcnt_q == '0);
  assign mismatch_cnt = mcnt_q;
  assign fail_idx     = fidx_q;
  assign fail_data    = fdata_q;
  assign cycle_cnt    = cycle_q;

endmodule

// File: tb/tb_reg_checkpoint_monitor.sv
module tb_reg_checkpoint_monitor;
  localparam int DATA_W = 32, ADDR_W = 5, NUM_CHECKS = 8, IDX_W = 3, CYCLE_W = 32;

  logic               clk, rst, cfg_we, cfg_en, arm;
  logic [IDX_W-1:0]   cfg_idx;
  logic [ADDR_W-1:0]  cfg_reg, rd_addr;
  logic [DATA_W-1:0]  cfg_val, rd_data, fail_data;
  logic [CYCLE_W-1:0] target_cycle, cycle_cnt;
  logic               busy, done, pass;
  logic [IDX_W:0]     mismatch_cnt;
  logic [IDX_W-1:0]   fail_idx;

  logic [DATA_W-1:0]  regs [32];
  logic               m_en  [NUM_CHECKS];
  logic [ADDR_W-1:0]  m_reg [NUM_CHECKS];
  logic [DATA_W-1:0]  m_val [NUM_CHECKS];

  typedef struct {
    logic             pass;
    logic [IDX_W:0]   mcnt;
    logic [IDX_W-1:0] fidx;
    logic [DATA_W-1:0] fdata;
    logic [CYCLE_W-1:0] cyc;
    int               lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;

  reg_checkpoint_monitor #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS),
                           .IDX_W(IDX_W), .CYCLE_W(CYCLE_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_reg(cfg_reg), .cfg_val(cfg_val), .target_cycle(target_cycle), .arm(arm),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .fail_idx(fail_idx), .fail_data(fail_data),
    .cycle_cnt(cycle_cnt)
  );

  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model_exp(input logic [CYCLE_W-1:0] tgt);
    exp_t e;
    e.mcnt = '0; e.fidx = '0; e.fdata = '0;
    e.cyc = (tgt == 0) ? CYCLE_W'(1) : tgt;
    e.lat = int'(e.cyc) + NUM_CHECKS;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (m_en[i] && regs[m_reg[i]] !== m_val[i]) begin
        if (e.mcnt == 0) begin
          e.fidx  = IDX_W'(i);
          e.fdata = regs[m_reg[i]];
        end
        e.mcnt = e.mcnt + 1'b1;
      end
    end
    e.pass = (e.mcnt == 0);
    return e;
  endfunction

  task automatic cfg_write(input int idx, input logic en, input logic [ADDR_W-1:0] r,
                           input logic [DATA_W-1:0] v, input bit upd);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_en = en; cfg_reg = r; cfg_val = v;
    if (upd) begin m_en[idx] = en; m_reg[idx] = r; m_val[idx] = v; end
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input logic [CYCLE_W-1:0] tgt, input bit push);
    if (push) sb.push_back(model_exp(tgt));
    target_cycle = tgt; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic load_table();
    cfg_write(0, 1'b1, 5'd19, 32'd45, 1'b1);
    cfg_write(1, 1'b1, 5'd20, 32'd10, 1'b1);
    cfg_write(2, 1'b1, 5'd21, 32'd3,  1'b1);
    cfg_write(3, 1'b1, 5'd22, 32'd2,  1'b1);
  endtask

  task automatic good_regs();
    regs[19] = 32'd45; regs[20] = 32'd10; regs[21] = 32'd3; regs[22] = 32'd2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, pass, mismatch_cnt, fail_idx, fail_data, cycle_cnt, rd_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b mcnt=%0d fidx=%0d fdata=%0d cyc=%0d rd_addr=%0d, want all 0",
               busy, done, pass, mismatch_cnt, fail_idx, fail_data, cycle_cnt, rd_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_match();
    exp_t e; int n = 0;
    load_table();
    good_regs();
    start_run(32'd14, 1'b1);
    checks++;
    if (busy !== 1'b1 || cycle_cnt !== 32'd1) begin
      failures++;
      $display("FAIL match_arm: got busy=%b cycle_cnt=%0d, want busy=1 cycle_cnt=1", busy, cycle_cnt);
    end
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat) begin failures++; $display("FAIL match_latency: got %0d cycles, want %0d", n, e.lat); end
    checks++;
    if (pass !== e.pass || mismatch_cnt !== e.mcnt) begin
      failures++; $display("FAIL match_result: got pass=%b mcnt=%0d, want pass=%b mcnt=%0d", pass, mismatch_cnt, e.pass, e.mcnt);
    end
    checks++;
    if (cycle_cnt !== e.cyc) begin failures++; $display("FAIL match_cycle_cnt: got %0d, want %0d", cycle_cnt, e.cyc); end
  endtask

  task automatic test_mismatch();
    exp_t e; int n = 0;
    regs[20] = 32'd11; regs[22] = 32'd7;
    start_run(32'd14, 1'b1);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat) begin failures++; $display("FAIL mismatch_latency: got %0d, want %0d", n, e.lat); end
    checks++;
    if (pass !== e.pass || mismatch_cnt !== e.mcnt) begin
      failures++; $display("FAIL mismatch_result: got pass=%b mcnt=%0d, want pass=%b mcnt=%0d", pass, mismatch_cnt, e.pass, e.mcnt);
    end
    checks++;
    if (fail_idx !== e.fidx || fail_data !== e.fdata) begin
      failures++; $display("FAIL mismatch_first: got idx=%0d data=%0d, want idx=%0d data=%0d", fail_idx, fail_data, e.fidx, e.fdata);
    end
  endtask

  task automatic test_rearm();
    exp_t e; int n = 0;
    good_regs();
    start_run(32'd3, 1'b1);
    checks++;
    if ({done, pass, mismatch_cnt, fail_idx, fail_data} !== '0) begin
      failures++; $display("FAIL rearm_clear: got done=%b pass=%b mcnt=%0d fidx=%0d fdata=%0d, want all 0",
                           done, pass, mismatch_cnt, fail_idx, fail_data);
    end
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat || pass !== e.pass || mismatch_cnt !== e.mcnt) begin
      failures++; $display("FAIL rearm_result: got lat=%0d pass=%b mcnt=%0d, want lat=%0d pass=%b mcnt=%0d",
                           n, pass, mismatch_cnt, e.lat, e.pass, e.mcnt);
    end
  endtask

  task automatic test_target_edges();
    exp_t e;
    for (int t = 0; t < 2; t++) begin
      int n = 0;
      start_run(CYCLE_W'(t), 1'b1);
      checks++;
      if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL target%0d_arm_cnt: got %0d, want 1", t, cycle_cnt); end
      wait_done(n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat || cycle_cnt !== e.cyc || pass !== e.pass) begin
        failures++; $display("FAIL target%0d_run: got lat=%0d cyc=%0d pass=%b, want lat=%0d cyc=%0d pass=%b",
                             t, n, cycle_cnt, pass, e.lat, e.cyc, e.pass);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int n = 0;
    regs[5] = 32'd78;
    cfg_we = 1'b1; cfg_idx = 3'd4; cfg_en = 1'b1; cfg_reg = 5'd5; cfg_val = 32'd77;
    m_en[4] = 1'b1; m_reg[4] = 5'd5; m_val[4] = 32'd77;
    sb.push_back(model_exp(32'd2));
    target_cycle = 32'd2; arm = 1'b1;
    tick();
    arm = 1'b0; cfg_we = 1'b0;
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat || pass !== e.pass || mismatch_cnt !== e.mcnt || fail_idx !== e.fidx || fail_data !== e.fdata) begin
      failures++; $display("FAIL back_to_back: got lat=%0d pass=%b mcnt=%0d fidx=%0d fdata=%0d, want lat=%0d pass=%b mcnt=%0d fidx=%0d fdata=%0d",
                           n, pass, mismatch_cnt, fail_idx, fail_data, e.lat, e.pass, e.mcnt, e.fidx, e.fdata);
    end
    cfg_write(4, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_ignored();
    exp_t e; int n = 0;
    start_run(32'd5, 1'b1);
    tick(); n++;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_reg = 5'd19; cfg_val = 32'd999;
    tick(); n++;
    cfg_we = 1'b0;
    while (n < 6) begin tick(); n++; end
    target_cycle = 32'd1; arm = 1'b1;
    tick(); n++;
    arm = 1'b0;
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat || cycle_cnt !== e.cyc) begin
      failures++; $display("FAIL ignored_timing: got lat=%0d cyc=%0d, want lat=%0d cyc=%0d", n, cycle_cnt, e.lat, e.cyc);
    end
    checks++;
    if (pass !== e.pass || mismatch_cnt !== e.mcnt) begin
      failures++; $display("FAIL ignored_result: got pass=%b mcnt=%0d, want pass=%b mcnt=%0d", pass, mismatch_cnt, e.pass, e.mcnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e; int n = 0;
    regs[19] = 32'd0; regs[21] = 32'd99;
    start_run(32'd2, 1'b0);
    tick(); tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || rd_addr !== m_reg[2]) begin
      failures++; $display("FAIL scan3_rd_addr: got busy=%b rd_addr=%0d, want busy=1 rd_addr=%0d", busy, rd_addr, m_reg[2]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) m_en[i] = 1'b0;
    checks++;
    if ({busy, done, pass, mismatch_cnt, fail_idx, fail_data, cycle_cnt, rd_addr} !== '0) begin
      failures++; $display("FAIL abort_outputs: got busy=%b done=%b mcnt=%0d fidx=%0d fdata=%0d cyc=%0d, want all 0",
                           busy, done, mismatch_cnt, fail_idx, fail_data, cycle_cnt);
    end
    start_run(32'd3, 1'b1);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat || pass !== e.pass || mismatch_cnt !== e.mcnt) begin
      failures++; $display("FAIL empty_table: got lat=%0d pass=%b mcnt=%0d, want lat=%0d pass=%b mcnt=%0d",
                           n, pass, mismatch_cnt, e.lat, e.pass, e.mcnt);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_reg = '0; cfg_val = '0;
    arm = 1'b0; target_cycle = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3 + 100);
    for (int i = 0; i < NUM_CHECKS; i++) begin m_en[i] = 1'b0; m_reg[i] = '0; m_val[i] = '0; end
    test_reset();
    test_match();
    test_mismatch();
    test_rearm();
    test_target_edges();
    test_back_to_back();
    test_ignored();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
